// File: rtl/ifu.sv
// ifu: instruction fetch unit. Owns the PC, keeps at most one instruction-memory
// read in flight and drives the registered instruction/address pair for decode.
// Optional feature macro: IFU_ALIGN_CHECK_EN adds misaligned-redirect detection,
// a terminal S_HALT state and the fetch_misalign_o port.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
`ifdef IFU_ALIGN_CHECK_EN
  ,
  output logic        fetch_misalign_o
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_BUF  = 2'd2
`ifdef IFU_ALIGN_CHECK_EN
    ,
    S_HALT = 2'd3
`endif
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] pc;
  logic [31:0] pend_addr;
  logic        discard;
  logic [31:0] buf_inst;
  logic [31:0] buf_addr;

  logic        slot_free;
  logic        halted;
  logic        redir;
  logic        outstanding;
  logic [31:0] target;

  // Decode has taken (or never had) the current output, so it may be replaced.
  assign slot_free = !inst_valid_o || !stall;

  // A request is in flight past this edge if we are waiting with no response
  // arriving now, or memory accepts one this very cycle.
  assign outstanding = (state == S_WAIT && !imem_rsp_valid) ||
                       (state == S_REQ && imem_req_ready);

`ifdef IFU_ALIGN_CHECK_EN
  logic misalign;
  assign target   = redirect_pc;
  assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign halted   = (state == S_HALT);
`else
  assign target   = redirect_pc & 32'hFFFF_FFFC;
  assign halted   = 1'b0;
`endif

  // Once halted the unit is frozen until reset, redirects included.
  assign redir = redirect_valid && !halted;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_REQ;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a redirect overrides normal sequencing.
  always_comb begin
    next_state = state;
    if (redir) begin
`ifdef IFU_ALIGN_CHECK_EN
      if (misalign) begin
        next_state = S_HALT;
      end else if (outstanding) begin
        next_state = S_WAIT;
      end else begin
        next_state = S_REQ;
      end
`else
      if (outstanding) begin
        next_state = S_WAIT;
      end else begin
        next_state = S_REQ;
      end
`endif
    end else begin
      case (state)
        S_REQ:   if (imem_req_ready) next_state = S_WAIT;
        S_WAIT:  if (imem_rsp_valid) next_state = (discard || slot_free) ? S_REQ : S_BUF;
        S_BUF:   if (!stall) next_state = S_REQ;
        default: next_state = state;
      endcase
    end
  end

  // Memory request outputs; request is suppressed while reset is held.
  always_comb begin
    imem_req_valid = rst_n && (state == S_REQ);
    imem_req_addr  = pc;
  end

  // PC, pending address, discard flag, skid buffer and decode output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      pend_addr    <= '0;
      discard      <= 1'b0;
      buf_inst     <= '0;
      buf_addr     <= '0;
      inst_o       <= NOP;
      inst_addr_o  <= '0;
      inst_valid_o <= 1'b0;
    end else if (redir) begin
      pc           <= target;
      inst_o       <= NOP;
      inst_valid_o <= 1'b0;
      discard      <= outstanding;
      if (state == S_REQ && imem_req_ready) pend_addr <= pc;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_req_ready) pend_addr <= pc;
          if (slot_free) begin
            inst_o       <= NOP;
            inst_valid_o <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (discard) begin
              discard <= 1'b0;
              if (slot_free) begin
                inst_o       <= NOP;
                inst_valid_o <= 1'b0;
              end
            end else if (slot_free) begin
              inst_o       <= imem_rsp_data;
              inst_addr_o  <= pend_addr;
              inst_valid_o <= 1'b1;
              pc           <= pend_addr + 32'd4;
            end else begin
              buf_inst <= imem_rsp_data;
              buf_addr <= pend_addr;
              pc       <= pend_addr + 32'd4;
            end
          end else if (slot_free) begin
            inst_o       <= NOP;
            inst_valid_o <= 1'b0;
          end
        end
        S_BUF: begin
          if (!stall) begin
            inst_o       <= buf_inst;
            inst_addr_o  <= buf_addr;
            inst_valid_o <= 1'b1;
          end
        end
        default: begin
          if (slot_free) begin
            inst_o       <= NOP;
            inst_valid_o <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef IFU_ALIGN_CHECK_EN
  // Sticky misaligned-redirect flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_misalign_o <= 1'b0;
    end else if (redir && misalign) begin
      fetch_misalign_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu.sv
// tb_ifu: randomized bench for ifu against a transaction-level fetch model.
module tb_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
`ifdef IFU_ALIGN_CHECK_EN
  logic        fetch_misalign_o;
`endif

  ifu #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .inst_o         (inst_o),
    .inst_addr_o    (inst_addr_o),
    .inst_valid_o   (inst_valid_o)
`ifdef IFU_ALIGN_CHECK_EN
    ,
    .fetch_misalign_o (fetch_misalign_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  // Reference model: next address decode should receive, next address fetch
  // should request, and a single-slot memory with a latency countdown.
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] fetch_exp = RESET_PC;
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt = 0;
  int          lat_override = 1;
  int          ready_mode = 1;
  int          deliveries = 0;
  logic [31:0] last_addr = '0;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0010_0093;
    if (a == 32'h8000_0004) return 32'h0020_0113;
    return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: memory responds per model, checks run mid-cycle
  // (delivery, fetch order) and just after the edge (redirect, hold).
  task automatic cycle(input logic st, input logic rv, input logic [31:0] rp);
    logic        v, rq, sent;
    logic [31:0] a, d, ra, tgt;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rp;
    case (ready_mode)
      1:       imem_req_ready = 1'b1;
      2:       imem_req_ready = 1'b0;
      default: imem_req_ready = 1'($urandom_range(0, 1));
    endcase
    sent = 1'b0;
    if (mem_pend) begin
      if (mem_cnt == 0) sent = 1'b1;
      else mem_cnt--;
    end
    imem_rsp_valid = sent;
    imem_rsp_data  = sent ? word(mem_addr) : $urandom;
    #2;
    v   = inst_valid_o;
    a   = inst_addr_o;
    d   = inst_o;
    rq  = imem_req_valid;
    ra  = imem_req_addr;
    tgt = rp & 32'hFFFF_FFFC;
    if (!v) chk("bubble_inst", d, NOP);
    if (v && !st && !rv) begin
      chk("deliver_addr", a, exp_pc);
      chk("deliver_data", d, word(exp_pc));
      exp_pc    = exp_pc + 32'd4;
      deliveries++;
      last_addr = a;
    end
    if (sent) mem_pend = 1'b0;
    if (rq && imem_req_ready) begin
      chk("one_outstanding", 32'(mem_pend), 32'd0);
      chk("fetch_addr", ra, fetch_exp);
      fetch_exp = ra + 32'd4;
      mem_pend  = 1'b1;
      mem_addr  = ra;
      mem_cnt   = ((lat_override > 0) ? lat_override : int'($urandom_range(1, 3))) - 1;
    end
    if (rv) begin
      exp_pc    = tgt;
      fetch_exp = tgt;
    end
    @(posedge clk);
    #1;
    if (rv) begin
      chk("redir_valid", 32'(inst_valid_o), 32'd0);
      chk("redir_nop", inst_o, NOP);
      if (!mem_pend) begin
        chk("redir_req_addr", imem_req_addr, tgt);
        chk("redir_req_valid", 32'(imem_req_valid), 32'd1);
      end
    end else if (v && st) begin
      chk("hold_valid", 32'(inst_valid_o), 32'd1);
      chk("hold_addr", inst_addr_o, a);
      chk("hold_inst", inst_o, d);
    end
  endtask

  initial begin
    int d0;
    logic [31:0] rp;
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_inst", inst_o, NOP);
    chk("rst_inst_addr", inst_addr_o, 32'd0);
    chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
`ifdef IFU_ALIGN_CHECK_EN
    chk("rst_misalign", 32'(fetch_misalign_o), 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);

    // Back-to-back fetch, k=1, memory always ready.
    cycle(1'b0, 1'b0, '0);
    chk("lat_bubble", 32'(inst_valid_o), 32'd0);
    cycle(1'b0, 1'b0, '0);
    chk("lat_valid", 32'(inst_valid_o), 32'd1);
    chk("lat_addr0", inst_addr_o, 32'h8000_0000);
    chk("lat_inst0", inst_o, 32'h0010_0093);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    chk("addr1", inst_addr_o, 32'h8000_0004);
    chk("inst1", inst_o, 32'h0020_0113);

    // Stall while the next response lands in the buffer.
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    chk("buf_no_req", 32'(imem_req_valid), 32'd0);
    cycle(1'b1, 1'b0, '0);
    chk("buf_no_req2", 32'(imem_req_valid), 32'd0);
    cycle(1'b0, 1'b0, '0);
    chk("unstall_addr", inst_addr_o, 32'h8000_0008);
    chk("unstall_valid", 32'(inst_valid_o), 32'd1);

    // Redirect while a slow response is outstanding.
    lat_override = 3;
    for (int i = 0; i < 20 && !mem_pend; i++) cycle(1'b0, 1'b0, '0);
    chk("wait_reached", 32'(mem_pend), 32'd1);
    cycle(1'b0, 1'b1, 32'h8000_0100);
    lat_override = 1;
    d0 = deliveries;
    for (int i = 0; i < 30 && deliveries == d0; i++) cycle(1'b0, 1'b0, '0);
    chk("redir_first_addr", last_addr, 32'h8000_0100);

    // Redirect together with stall while holding a valid instruction.
    for (int i = 0; i < 20 && !inst_valid_o; i++) cycle(1'b1, 1'b0, '0);
    chk("held_before_redir", 32'(inst_valid_o), 32'd1);
    cycle(1'b1, 1'b1, 32'h8000_0200);
    d0 = deliveries;
    for (int i = 0; i < 30 && deliveries == d0; i++) cycle(1'b0, 1'b0, '0);
    chk("redir_stall_addr", last_addr, 32'h8000_0200);

    // Reset pulse in the middle of an outstanding request.
    lat_override = 3;
    for (int i = 0; i < 20 && !mem_pend; i++) cycle(1'b0, 1'b0, '0);
    chk("wait_before_rst", 32'(mem_pend), 32'd1);
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("mid_rst_inst_valid", 32'(inst_valid_o), 32'd0);
    rst_n = 1'b1; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = word(mem_addr);
    #1;
    chk("post_rst_req_addr", imem_req_addr, RESET_PC);
    chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    chk("late_rsp_ignored", 32'(inst_valid_o), 32'd0);
    chk("late_rsp_still_req", 32'(imem_req_valid), 32'd1);
    mem_pend = 1'b0; exp_pc = RESET_PC; fetch_exp = RESET_PC;
    lat_override = 1; ready_mode = 1;
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    chk("rst_refetch_addr", inst_addr_o, RESET_PC);
    chk("rst_refetch_valid", 32'(inst_valid_o), 32'd1);

    // Randomized traffic: stalls, redirects (incl. wrap region), ready, latency.
    ready_mode = 0; lat_override = 0;
    for (int i = 0; i < 600; i++) begin
      rp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8
                                       : (32'h8000_0000 + (32'($urandom_range(0, 63)) << 2));
`ifndef IFU_ALIGN_CHECK_EN
      rp = rp | 32'($urandom_range(0, 3));
`endif
      cycle(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 19) == 0), rp);
    end
    ready_mode = 1;
    d0 = deliveries;
    repeat (10) cycle(1'b0, 1'b0, '0);
    chk("progress", 32'(deliveries > d0), 32'd1);

    // Misaligned redirect.
    ready_mode = 2;
    for (int i = 0; i < 10 && mem_pend; i++) cycle(1'b0, 1'b0, '0);
    chk("drained", 32'(mem_pend), 32'd0);
`ifdef IFU_ALIGN_CHECK_EN
    stall = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    chk("misalign_flag", 32'(fetch_misalign_o), 32'd1);
    chk("misalign_bubble", 32'(inst_valid_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("halt_no_req", 32'(imem_req_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("misalign_sticky", 32'(fetch_misalign_o), 32'd1);
`else
    ready_mode = 1; lat_override = 1;
    cycle(1'b0, 1'b1, 32'h8000_0102);
    chk("align_force_addr", imem_req_addr, 32'h8000_0100);
    d0 = deliveries;
    for (int i = 0; i < 10 && deliveries == d0; i++) cycle(1'b0, 1'b0, '0);
    chk("align_force_deliver", last_addr, 32'h8000_0100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
